// File: rtl/register_bank_param.sv
// Parametrised integer register bank: two combinational read ports, one write port,
// reset-driven clear sequencer, optional bypass and hardwired-zero register 0.
module register_bank_param #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter bit                 ZERO_REG = 1'b1,
    parameter bit                 BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r_op_a,
    input  logic [ADDR_W-1:0] r_op_b,
    input  logic [ADDR_W-1:0] r_write,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              busy,
    output logic              wr_drop
);

    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              drop_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [NREGS];

    // A write aimed at the hardwired-zero register is neither stored nor forwarded.
    logic wr_zero_blocked;
    assign wr_zero_blocked = ZERO_REG && (r_write == '0);

    assign busy = (state == CLEAR);

    // The clear sequencer and the user port share one physical write port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_nxt  = wr_drop;
        mem_we    = 1'b0;
        mem_waddr = r_write;
        mem_wdata = w_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = CLR_VAL;
                if (w_en)
                    drop_nxt = 1'b1;
                // Terminate on compare so cnt never wraps back to 0.
                if (cnt == LAST_IDX)
                    state_nxt = READY;
                else
                    cnt_nxt = cnt + ADDR_W'(1);
            end
            READY: begin
                mem_we = w_en && !wr_zero_blocked;
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_drop <= drop_nxt;
        end
    end

    // NOTE: the storage array has no reset branch; the clear sequencer initialises it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (state != READY)
            return '0;
        if (ZERO_REG && (addr == '0))
            return '0;
        if (BYPASS && w_en && !wr_zero_blocked && (r_write == addr))
            return w_data;
        return mem[addr];
    endfunction

    always_comb begin
        rd_a = read_port(r_op_a);
        rd_b = read_port(r_op_b);
    end

endmodule
